// File: rtl/dmem_map_pkg.sv
// rtl/dmem_map_pkg.sv - dmem responder address map, STATUS layout and region select
package dmem_map_pkg;

    localparam logic [31:0] OFF_TXDATA = 32'h0000_0000;
    localparam logic [31:0] OFF_STATUS = 32'h0000_0004;
    localparam logic [31:0] OFF_CYCLE  = 32'h0000_0008;
    localparam logic [31:0] OFF_TOHOST = 32'h0000_000C;

    localparam int STAT_EMPTY   = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_OVF     = 2;
    localparam int STAT_CNT_LSB = 3;
    localparam int STAT_CNT_W   = 5;

    typedef enum logic [2:0] {
        SEL_RAM,
        SEL_TX,
        SEL_STAT,
        SEL_CYC,
        SEL_HOST,
        SEL_NONE
    } regionSel_e;

    // Packs the STATUS read word; all bits above the count field read zero.
    function automatic logic [31:0] statusWord(
        input logic [STAT_CNT_W-1:0] count,
        input logic                  ovf,
        input logic                  full,
        input logic                  empty
    );
        logic [31:0] w;
        w                                = '0;
        w[STAT_EMPTY]                    = empty;
        w[STAT_FULL]                     = full;
        w[STAT_OVF]                      = ovf;
        w[STAT_CNT_LSB +: STAT_CNT_W]    = count;
        return w;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - dmem port, console stream and halt signals of the responder
interface dmem_responder_if;
    logic [31:0] dmemAddr;
    logic [31:0] dmemWdata;
    logic        dmemWen;
    logic [31:0] dmemRdata;
    logic [7:0]  txData;
    logic        txValid;
    logic        txReady;
    logic        halt;
    logic [31:0] haltCode;

    // Core / SoC side: drives the memory request and the console consumer ready.
    modport master (
        output dmemAddr, dmemWdata, dmemWen, txReady,
        input  dmemRdata, txData, txValid, halt, haltCode
    );

    // Responder side.
    modport slave (
        input  dmemAddr, dmemWdata, dmemWen, txReady,
        output dmemRdata, txData, txValid, halt, haltCode
    );
endinterface

// File: rtl/tx_fifo.sv
// rtl/tx_fifo.sv - console transmit FIFO with push-while-full-and-popping support
module tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rstN,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic             doPop;
    logic             doPush;

    assign empty  = (count == '0);
    assign full   = (count == (PW+1)'(DEPTH));
    assign doPop  = pop && !empty;
    // When full, the slot being popped this edge is the one the push lands in.
    assign doPush = push && (!full || doPop);
    assign rdata  = empty ? '0 : mem[rptr];

    // Pointers wrap naturally since DEPTH is a power of two; count tracks occupancy.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (doPush) wptr <= wptr + 1'b1;
            if (doPop)  rptr <= rptr + 1'b1;
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Byte storage; contents are don't-care after reset because count is zero.
    always_ff @(posedge clk) begin
        if (doPush) mem[wptr] <= wdata;
    end
endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - word RAM plus MMIO console, cycle counter and tohost registers
module dmem_responder
    import dmem_map_pkg::*;
#(
    parameter int          RAM_WORDS  = 1024,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'h1000_0000
) (
    input logic              clk,
    input logic              rstN,
    dmem_responder_if.slave  bus
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    regionSel_e    sel;
    logic [29:0]   wordAddr;
    logic [29:0]   mmioWord;
    logic [AW-1:0] ramIdx;
    logic          unusedByteLane;

    logic [31:0]   mem [RAM_WORDS];

    logic          storeRam;
    logic          storeTx;
    logic          storeStat;
    logic          storeCyc;
    logic          storeHost;

    logic          fifoFull;
    logic          fifoEmpty;
    logic [CW-1:0] fifoCount;
    logic [7:0]    fifoData;
    logic          popNow;

    logic          overflow;
    logic [31:0]   cycle;
    logic          haltReg;
    logic [31:0]   haltCodeReg;

    assign wordAddr       = bus.dmemAddr[31:2];
    assign mmioWord       = MMIO_BASE[31:2];
    assign ramIdx         = bus.dmemAddr[AW+1:2];
    assign unusedByteLane = ^bus.dmemAddr[1:0];

    // Region decode on the word address; anything unmatched is a silent hole.
    always_comb begin
        sel = SEL_NONE;
        if (wordAddr < 30'(RAM_WORDS))
            sel = SEL_RAM;
        else if (wordAddr == mmioWord + OFF_TXDATA[31:2])
            sel = SEL_TX;
        else if (wordAddr == mmioWord + OFF_STATUS[31:2])
            sel = SEL_STAT;
        else if (wordAddr == mmioWord + OFF_CYCLE[31:2])
            sel = SEL_CYC;
        else if (wordAddr == mmioWord + OFF_TOHOST[31:2])
            sel = SEL_HOST;
    end

    assign storeRam  = bus.dmemWen && (sel == SEL_RAM);
    assign storeTx   = bus.dmemWen && (sel == SEL_TX);
    assign storeStat = bus.dmemWen && (sel == SEL_STAT);
    assign storeCyc  = bus.dmemWen && (sel == SEL_CYC);
    assign storeHost = bus.dmemWen && (sel == SEL_HOST);

    assign popNow = !fifoEmpty && bus.txReady;

    tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk   (clk),
        .rstN  (rstN),
        .push  (storeTx),
        .pop   (popNow),
        .wdata (bus.dmemWdata[7:0]),
        .rdata (fifoData),
        .full  (fifoFull),
        .empty (fifoEmpty),
        .count (fifoCount)
    );

    assign bus.txData   = fifoData;
    assign bus.txValid  = !fifoEmpty;
    assign bus.halt     = haltReg;
    assign bus.haltCode = haltCodeReg;

    // Word RAM: stores commit at the edge, contents survive reset.
    always_ff @(posedge clk) begin
        if (storeRam) mem[ramIdx] <= bus.dmemWdata;
    end

    // Sticky overflow: set by a dropped push, cleared by a STATUS store with bit 2 set.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)
            overflow <= 1'b0;
        else if (storeTx && fifoFull && !popNow)
            overflow <= 1'b1;
        else if (storeStat && bus.dmemWdata[STAT_OVF])
            overflow <= 1'b0;
    end

    // Free-running cycle counter; a store replaces the increment for that edge.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)
            cycle <= '0;
        else if (storeCyc)
            cycle <= bus.dmemWdata;
        else
            cycle <= cycle + 32'd1;
    end

    // First TOHOST store wins; later ones are ignored until reset.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            haltReg     <= 1'b0;
            haltCodeReg <= '0;
        end else if (storeHost && !haltReg) begin
            haltReg     <= 1'b1;
            haltCodeReg <= bus.dmemWdata;
        end
    end

    // Zero-latency load mux; write-only registers and holes read as zero.
    always_comb begin
        bus.dmemRdata = '0;
        case (sel)
            SEL_RAM:  bus.dmemRdata = mem[ramIdx];
            SEL_STAT: bus.dmemRdata = statusWord(STAT_CNT_W'(fifoCount), overflow,
                                                 fifoFull, fifoEmpty);
            SEL_CYC:  bus.dmemRdata = cycle;
            default:  bus.dmemRdata = '0;
        endcase
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized and directed self-checking bench for dmem_responder
module tb_dmem_responder;
    localparam int          DEPTH  = 8;
    localparam logic [31:0] MB     = 32'h1000_0000;
    localparam logic [31:0] A_TX   = MB + 32'h0;
    localparam logic [31:0] A_STAT = MB + 32'h4;
    localparam logic [31:0] A_CYC  = MB + 32'h8;
    localparam logic [31:0] A_HOST = MB + 32'hC;
    localparam logic [31:0] RAM_BYTES = 32'd4096;

    logic clk  = 1'b0;
    logic rstN = 1'b0;
    always #5 clk = ~clk;

    dmem_responder_if bus();

    dmem_responder #(
        .RAM_WORDS  (1024),
        .FIFO_DEPTH (DEPTH),
        .MMIO_BASE  (MB)
    ) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    int nChecks = 0;
    int nErrors = 0;

    logic [31:0] mRam [int];
    logic [7:0]  mQ[$];
    bit          mOvf;
    bit          mHalt;
    logic [31:0] mCode;
    logic [31:0] mCyc;
    logic [31:0] wrAddrs[$];

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void mReset();
        mQ.delete();
        mOvf  = 0;
        mHalt = 0;
        mCode = 0;
        mCyc  = 0;
    endfunction

    function automatic logic [31:0] expRead(input logic [31:0] a);
        int n;
        n = mQ.size();
        if (a < RAM_BYTES)
            return mRam.exists(int'(a[31:2])) ? mRam[int'(a[31:2])] : 32'hx;
        if ((a & ~32'h3) == A_STAT)
            return 32'(n * 8 + (mOvf ? 4 : 0) + (n == DEPTH ? 2 : 0) + (n == 0 ? 1 : 0));
        if ((a & ~32'h3) == A_CYC)
            return mCyc;
        return 32'h0;
    endfunction

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic we);
        bus.dmemAddr  = a;
        bus.dmemWdata = d;
        bus.dmemWen   = we;
        #1;
    endtask

    // One clock edge; the model applies the same edge using the inputs seen before it.
    task automatic tick();
        logic [31:0] a;
        logic [31:0] d;
        logic        we;
        bit          pop;
        bit          pushB;
        a     = bus.dmemAddr;
        d     = bus.dmemWdata;
        we    = bus.dmemWen;
        pop   = (mQ.size() > 0) && bus.txReady;
        pushB = 0;
        @(posedge clk);
        #1;
        if (we) begin
            if (a < RAM_BYTES) begin
                if (!mRam.exists(int'(a[31:2]))) wrAddrs.push_back(a);
                mRam[int'(a[31:2])] = d;
            end else if ((a & ~32'h3) == A_TX) begin
                if (mQ.size() < DEPTH || pop) pushB = 1;
                else mOvf = 1;
            end else if ((a & ~32'h3) == A_STAT) begin
                if (d[2]) mOvf = 0;
            end else if ((a & ~32'h3) == A_HOST) begin
                if (!mHalt) begin
                    mHalt = 1;
                    mCode = d;
                end
            end
        end
        if (pop) void'(mQ.pop_front());
        if (pushB) mQ.push_back(d[7:0]);
        if (we && (a & ~32'h3) == A_CYC) mCyc = d;
        else mCyc = mCyc + 32'd1;
    endtask

    task automatic checkOutputs(input string tag);
        logic [31:0] e;
        e = expRead(bus.dmemAddr);
        if (!$isunknown(e)) checkEq({tag, "_rdata"}, bus.dmemRdata, e);
        checkEq({tag, "_txValid"}, 32'(bus.txValid), 32'(mQ.size() > 0));
        if (mQ.size() > 0) checkEq({tag, "_txData"}, 32'(bus.txData), 32'(mQ[0]));
        checkEq({tag, "_halt"}, 32'(bus.halt), 32'(mHalt));
    endtask

    initial begin
        logic [7:0] exp4[$];
        int op;
        bus.dmemAddr  = 0;
        bus.dmemWdata = 0;
        bus.dmemWen   = 0;
        bus.txReady   = 0;
        mReset();

        // Reset state
        #12;
        drive(A_STAT, 0, 0);
        checkEq("rst_status", bus.dmemRdata, 32'h1);
        checkEq("rst_txValid", 32'(bus.txValid), 32'h0);
        checkEq("rst_txData", 32'(bus.txData), 32'h0);
        checkEq("rst_halt", 32'(bus.halt), 32'h0);
        checkEq("rst_haltCode", bus.haltCode, 32'h0);
        #9;
        rstN = 1'b1;

        // 1: RAM store then load, byte offset ignored
        drive(32'h40, 32'hDEAD_BEEF, 1);
        tick();
        drive(32'h40, 0, 0);
        checkEq("t1_ram", bus.dmemRdata, 32'hDEAD_BEEF);
        drive(32'h42, 0, 0);
        checkEq("t1_ram_unaligned", bus.dmemRdata, 32'hDEAD_BEEF);

        // 2: two bytes queued, then drained in order
        bus.txReady = 0;
        drive(A_TX, 32'h41, 1);
        tick();
        drive(A_TX, 32'h42, 1);
        tick();
        drive(A_STAT, 0, 0);
        checkEq("t2_status", bus.dmemRdata, 32'h10);
        checkEq("t2_head", 32'(bus.txData), 32'h41);
        bus.txReady = 1;
        drive(32'h40, 0, 0);
        tick();
        checkEq("t2_second", 32'(bus.txData), 32'h42);
        checkEq("t2_valid1", 32'(bus.txValid), 32'h1);
        tick();
        checkEq("t2_valid0", 32'(bus.txValid), 32'h0);
        bus.txReady = 0;

        // 3: overflow on the ninth push, clear via STATUS store
        for (int i = 0; i < 8; i++) begin
            drive(A_TX, 32'h60 + 32'(i), 1);
            tick();
        end
        drive(A_STAT, 0, 0);
        checkEq("t3_full", bus.dmemRdata, 32'h42);
        drive(A_TX, 32'h99, 1);
        tick();
        drive(A_STAT, 0, 0);
        checkEq("t3_ovf", bus.dmemRdata, 32'h46);
        drive(A_STAT, 32'h4, 1);
        tick();
        drive(A_STAT, 0, 0);
        checkEq("t3_ovf_clr", bus.dmemRdata, 32'h42);
        bus.txReady = 1;
        for (int i = 0; i < 8; i++) begin
            checkEq("t3_drain", 32'(bus.txData), 32'h60 + 32'(i));
            tick();
        end
        checkEq("t3_empty", 32'(bus.txValid), 32'h0);
        bus.txReady = 0;

        // 4: push while full and popping is accepted and lands last
        for (int i = 0; i < 8; i++) begin
            drive(A_TX, 32'h70 + 32'(i), 1);
            tick();
        end
        bus.txReady = 1;
        drive(A_TX, 32'h5A, 1);
        checkEq("t4_head", 32'(bus.txData), 32'h70);
        tick();
        drive(A_STAT, 0, 0);
        checkEq("t4_status", bus.dmemRdata, 32'h42);
        for (int i = 1; i < 8; i++) exp4.push_back(8'h70 + 8'(i));
        exp4.push_back(8'h5A);
        foreach (exp4[i]) begin
            checkEq("t4_drain", 32'(bus.txData), 32'(exp4[i]));
            tick();
        end
        checkEq("t4_empty", 32'(bus.txValid), 32'h0);
        bus.txReady = 0;

        // 5: CYCLE load, wrap, and store-cycle read returning the old value
        drive(A_CYC, 32'hFFFF_FFFE, 1);
        tick();
        drive(A_CYC, 0, 0);
        checkEq("t5_loaded", bus.dmemRdata, 32'hFFFF_FFFE);
        tick();
        checkEq("t5_max", bus.dmemRdata, 32'hFFFF_FFFF);
        tick();
        checkEq("t5_wrap", bus.dmemRdata, 32'h0);
        drive(A_CYC, 32'h1234, 1);
        checkEq("t5_prestore", bus.dmemRdata, mCyc);
        tick();
        drive(A_CYC, 0, 0);
        checkEq("t5_store", bus.dmemRdata, 32'h1234);

        // Randomized traffic against the model
        for (int it = 0; it < 600; it++) begin
            bus.txReady = (it < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
            op = $urandom_range(0, 7);
            case (op)
                0: drive(32'($urandom_range(0, 255)) * 4 + 32'($urandom_range(0, 3)), $urandom, 1);
                1: if (wrAddrs.size() > 0)
                       drive(wrAddrs[$urandom_range(0, wrAddrs.size() - 1)], 0, 0);
                   else
                       drive(A_STAT, 0, 0);
                2, 3: drive(A_TX, $urandom, 1);
                4: drive(A_STAT, 0, 0);
                5: drive(A_STAT, $urandom, 1);
                6: drive(A_CYC, 0, 0);
                default: drive(32'h2000_0000 + 32'($urandom_range(0, 1023)), $urandom, $urandom_range(0, 1) == 1);
            endcase
            checkOutputs("rnd");
            tick();
        end
        bus.txReady = 0;

        // 6: TOHOST first-store-wins, asynchronous reset mid-drain, holes
        drive(A_HOST, 32'h1, 1);
        tick();
        drive(A_HOST, 32'h7, 1);
        tick();
        drive(A_HOST, 0, 0);
        checkEq("t6_halt", 32'(bus.halt), 32'h1);
        checkEq("t6_code", bus.haltCode, 32'h1);
        checkEq("t6_host_rd", bus.dmemRdata, 32'h0);
        drive(A_TX, 32'h11, 1);
        tick();
        drive(A_TX, 32'h22, 1);
        tick();
        drive(32'h0, 0, 0);
        checkEq("t6_prerst_valid", 32'(bus.txValid), 32'h1);
        rstN = 1'b0;
        #1;
        mReset();
        checkEq("t6_rst_halt", 32'(bus.halt), 32'h0);
        checkEq("t6_rst_code", bus.haltCode, 32'h0);
        checkEq("t6_rst_valid", 32'(bus.txValid), 32'h0);
        checkEq("t6_rst_txData", 32'(bus.txData), 32'h0);
        drive(A_STAT, 0, 0);
        checkEq("t6_rst_status", bus.dmemRdata, 32'h1);
        rstN = 1'b1;
        drive(32'h2000_0000, 0, 0);
        checkEq("t6_unmapped", bus.dmemRdata, 32'h0);
        drive(32'h0000_0FFC, 32'hCAFE_F00D, 1);
        tick();
        drive(32'h0000_1000, 32'h0000_00AA, 1);
        tick();
        drive(32'h0000_0FFC, 0, 0);
        checkEq("t6_ram_top", bus.dmemRdata, 32'hCAFE_F00D);
        drive(32'h0000_1000, 0, 0);
        checkEq("t6_ram_end", bus.dmemRdata, 32'h0);
        drive(MB + 32'h10, 0, 0);
        checkEq("t6_mmio_hole", bus.dmemRdata, 32'h0);
        drive(A_CYC, 0, 0);
        checkEq("t6_cyc_after_rst", bus.dmemRdata, mCyc);
        checkOutputs("t6_final");

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end
endmodule
